// File: rtl/rgb_writer_pkg.sv
// Shared types and frame constants for the RGB write-back stage.
package rgb_writer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [17:0] RGB_BASE_ADDR = 18'd146944;
  localparam int unsigned NUM_PIXELS    = 76800;
  localparam int unsigned RGB_WORDS     = 3 * NUM_PIXELS / 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pixel_t;

  // Word emitted in each packing phase for the head pixel pair (p0, p1).
  function automatic logic [15:0] pack_word(input logic [1:0] phase,
                                            input rgb_pixel_t p0,
                                            input rgb_pixel_t p1);
    logic [15:0] w;
    unique case (phase)
      2'd0:    w = {p0.r, p0.g};
      2'd1:    w = {p0.b, p1.r};
      default: w = {p1.g, p1.b};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rgb_pixel_fifo.sv
// Small pixel buffer: one push per cycle, pops of zero or two, exposes the two head entries.
module rgb_pixel_fifo
  import rgb_writer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH),
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  rgb_pixel_t      push_data,
  input  logic            pop2,
  output logic [CntW-1:0] count,
  output rgb_pixel_t      head,
  output rgb_pixel_t      head_next
);

  rgb_pixel_t            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       rd_ptr_q;
  logic [PtrW-1:0]       wr_ptr_q;
  logic [CntW-1:0]       count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop2) rd_ptr_q <= rd_ptr_q + PtrW'(2);
      count_q <= count_q + CntW'(push) - (pop2 ? CntW'(2) : CntW'(0));
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign head_next = mem_q[rd_ptr_q + PtrW'(1)];

endmodule

// File: rtl/rgb_sram_writer.sv
// Packs pixel pairs into three 16-bit words and writes them sequentially into the SRAM RGB region.
module rgb_sram_writer
  import rgb_writer_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = rgb_writer_pkg::NUM_PIXELS,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        start,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_R,
  input  logic [7:0]  pix_G,
  input  logic [7:0]  pix_B,
  input  logic        write_grant,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        done
);

  localparam int unsigned Words = 3 * NUM_PIXELS / 2;
  localparam int unsigned PixW  = $clog2(NUM_PIXELS + 1);
  localparam int unsigned WordW = $clog2(Words + 1);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [PixW-1:0]  NumPixC = PixW'(NUM_PIXELS);
  localparam logic [WordW-1:0] WordsC  = WordW'(Words);
  localparam logic [CntW-1:0]  DepthC  = CntW'(FIFO_DEPTH);

  state_t            state_q, state_d;
  logic [PixW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [WordW-1:0]  word_cnt_q, word_cnt_d;
  logic [1:0]        phase_q, phase_d;
  logic [17:0]       wr_addr_q, wr_addr_d;
  logic [17:0]       sram_addr_q, sram_addr_d;
  logic [15:0]       sram_data_q, sram_data_d;
  logic              we_n_q, we_n_d;

  logic              push, pop2, issue, phase_ok;
  logic [CntW-1:0]   fifo_count;
  rgb_pixel_t        fifo_head, fifo_head_next, in_pixel;

  assign in_pixel  = '{r: pix_R, g: pix_G, b: pix_B};
  assign pix_ready = (state_q == S_RUN) && (fifo_count < DepthC) && (pix_cnt_q < NumPixC);
  assign push      = pix_valid && pix_ready;
  assign pop2      = issue && (phase_q == 2'd2);

  // Phase 0 only needs the first pixel of the pair; phases 1 and 2 need both.
  assign phase_ok  = (phase_q == 2'd0) ? (fifo_count >= CntW'(1)) : (fifo_count >= CntW'(2));

  rgb_pixel_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (Clock_50),
    .rst      (Reset),
    .push     (push),
    .push_data(in_pixel),
    .pop2     (pop2),
    .count    (fifo_count),
    .head     (fifo_head),
    .head_next(fifo_head_next)
  );

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    word_cnt_d  = word_cnt_q;
    phase_d     = phase_q;
    wr_addr_d   = wr_addr_q;
    sram_addr_d = sram_addr_q;
    sram_data_d = sram_data_q;
    we_n_d      = 1'b1;
    issue       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          pix_cnt_d  = '0;
          word_cnt_d = '0;
          phase_d    = 2'd0;
          wr_addr_d  = RGB_BASE_ADDR;
        end
      end
      S_RUN: begin
        if (word_cnt_q == WordsC) begin
          state_d = S_DONE;
        end else begin
          issue = write_grant && phase_ok;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (push) pix_cnt_d = pix_cnt_q + PixW'(1);

    if (issue) begin
      sram_addr_d = wr_addr_q;
      sram_data_d = pack_word(phase_q, fifo_head, fifo_head_next);
      we_n_d      = 1'b0;
      wr_addr_d   = wr_addr_q + 18'd1;
      word_cnt_d  = word_cnt_q + WordW'(1);
      phase_d     = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
    end
  end

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      pix_cnt_q   <= '0;
      word_cnt_q  <= '0;
      phase_q     <= 2'd0;
      wr_addr_q   <= '0;
      sram_addr_q <= '0;
      sram_data_q <= '0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      word_cnt_q  <= word_cnt_d;
      phase_q     <= phase_d;
      wr_addr_q   <= wr_addr_d;
      sram_addr_q <= sram_addr_d;
      sram_data_q <= sram_data_d;
      we_n_q      <= we_n_d;
    end
  end

  assign SRAM_address    = sram_addr_q;
  assign SRAM_write_data = sram_data_q;
  assign SRAM_we_n       = we_n_q;
  assign done            = (state_q == S_DONE);

endmodule

// File: tb/tb_rgb_sram_writer.sv
// Scoreboard bench for rgb_sram_writer using a reduced 40-pixel frame.
module tb_rgb_sram_writer;

  localparam int unsigned NPix   = 40;
  localparam int unsigned NWords = 3 * NPix / 2;
  localparam logic [17:0] Base   = 18'd146944;
  localparam logic [17:0] Final  = Base + 18'(NWords - 1);

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
  } exp_t;

  logic        Clock_50 = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  pix_R = '0, pix_G = '0, pix_B = '0;
  logic        write_grant = 1'b0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        done;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;

  exp_t        exp_q[$];
  logic [17:0] exp_addr;
  bit          have_half;
  logic [23:0] half_pix;

  bit          prev_wr = 0;
  logic [17:0] prev_addr = '0;

  rgb_sram_writer #(
    .NUM_PIXELS(NPix),
    .FIFO_DEPTH(4)
  ) dut (
    .Clock_50       (Clock_50),
    .Reset          (Reset),
    .start          (start),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_R          (pix_R),
    .pix_G          (pix_G),
    .pix_B          (pix_B),
    .write_grant    (write_grant),
    .SRAM_address   (SRAM_address),
    .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n      (SRAM_we_n),
    .done           (done)
  );

  always #5 Clock_50 = ~Clock_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [17:0] a, input logic [15:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Reference packer: phase-0 word is known as soon as the first pixel of a pair is accepted.
  task automatic model_push(input logic [23:0] p);
    if (!have_half) begin
      push_exp(exp_addr, p[23:8]);
      exp_addr  = exp_addr + 18'd1;
      half_pix  = p;
      have_half = 1;
    end else begin
      push_exp(exp_addr, {half_pix[7:0], p[23:16]});
      push_exp(exp_addr + 18'd1, p[15:0]);
      exp_addr  = exp_addr + 18'd2;
      have_half = 0;
    end
  endtask

  function automatic logic [23:0] gen_pix(input int k);
    logic [7:0] r, g, b;
    r = 8'(k * 7 + 1);
    g = 8'(k * 13 + 2);
    b = 8'(k * 29 + 3);
    return {r, g, b};
  endfunction

  task automatic send_pixel(input logic [23:0] p, input bit mdl);
    int t;
    t = 0;
    pix_valid = 1'b1;
    {pix_R, pix_G, pix_B} = p;
    forever begin
      @(negedge Clock_50);
      if (pix_ready) break;
      t++;
      if (t > 200) begin
        check("pix_accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge Clock_50);
    #1;
    pix_valid = 1'b0;
    if (mdl) model_push(p);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge Clock_50);
    #1;
    start = 1'b0;
  endtask

  task automatic begin_frame();
    exp_addr  = Base;
    have_half = 0;
    pulse_start();
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 200 && done_cnt < target; i++) @(negedge Clock_50);
    check("done_count", done_cnt, target);
    check("queue_empty_at_done", exp_q.size(), 0);
  endtask

  // Monitor: every write must match the head of the expectation queue.
  always @(negedge Clock_50) begin
    if (!Reset) begin
      if (done) begin
        done_cnt++;
        check("done_after_final_write", {31'd0, prev_wr}, 1);
        check("done_prev_addr", prev_addr, Final);
      end
      if (!SRAM_we_n) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", SRAM_address, 18'h3ffff);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("write_addr", SRAM_address, e.addr);
          check("write_data", SRAM_write_data, e.data);
        end
        prev_wr   = 1;
        prev_addr = SRAM_address;
      end else begin
        prev_wr = 0;
      end
    end
  end

  initial begin
    int k, acc, wr;
    repeat (2) @(posedge Clock_50);
    #1;
    check("rst_we_n", SRAM_we_n, 1);
    check("rst_addr", SRAM_address, 0);
    check("rst_data", SRAM_write_data, 0);
    check("rst_done", done, 0);
    check("rst_ready", pix_ready, 0);
    Reset = 1'b0;
    @(posedge Clock_50);
    #1;
    check("idle_ready", pix_ready, 0);

    // Frame 1: hand-computed first pair, grant high.
    write_grant = 1'b1;
    begin_frame();
    push_exp(Base, 16'h1122);
    push_exp(Base + 18'd1, 16'h3344);
    push_exp(Base + 18'd2, 16'h5566);
    send_pixel(24'h112233, 0);
    send_pixel(24'h445566, 0);
    repeat (5) @(posedge Clock_50);
    #1;
    exp_addr = Base + 18'd3;

    // Grant gap after phase 1 of the second pair.
    write_grant = 1'b0;
    push_exp(Base + 18'd3, 16'hA1A2);
    push_exp(Base + 18'd4, 16'hA3B1);
    push_exp(Base + 18'd5, 16'hB2B3);
    send_pixel(24'hA1A2A3, 0);
    send_pixel(24'hB1B2B3, 0);
    write_grant = 1'b1;
    repeat (2) @(posedge Clock_50);
    #1;
    write_grant = 1'b0;
    @(negedge Clock_50);
    wr = 0;
    repeat (5) begin
      @(negedge Clock_50);
      if (!SRAM_we_n) wr++;
    end
    check("gap_writes", wr, 0);
    check("gap_pending", exp_q.size(), 1);
    @(posedge Clock_50);
    #1;
    write_grant = 1'b1;
    repeat (3) @(posedge Clock_50);
    #1;
    exp_addr = Base + 18'd6;

    // Backpressure: valid held, grant low -> exactly FIFO_DEPTH accepts.
    write_grant = 1'b0;
    k = 4;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      bit took;
      pix_valid = 1'b1;
      {pix_R, pix_G, pix_B} = gen_pix(k);
      @(negedge Clock_50);
      took = pix_ready;
      @(posedge Clock_50);
      #1;
      if (took) begin
        model_push(gen_pix(k));
        k++;
        acc++;
      end
    end
    pix_valid = 1'b0;
    check("backpressure_accepts", acc, 4);
    check("backpressure_ready", pix_ready, 0);
    write_grant = 1'b1;
    repeat (10) @(posedge Clock_50);
    #1;

    // Rest of the frame, with a stray start mid-run.
    while (k < NPix) begin
      send_pixel(gen_pix(k), 1);
      k++;
      if (k == 20) pulse_start();
    end
    wait_done(1);
    @(negedge Clock_50);
    check("post_done_ready", pix_ready, 0);

    // Frame 2: reset mid-frame.
    begin_frame();
    for (int i = 0; i < 12; i++) send_pixel(gen_pix(100 + i), 1);
    #2;
    Reset = 1'b1;
    #1;
    check("midrst_we_n", SRAM_we_n, 1);
    check("midrst_addr", SRAM_address, 0);
    check("midrst_data", SRAM_write_data, 0);
    check("midrst_done", done, 0);
    check("midrst_ready", pix_ready, 0);
    exp_q.delete();
    repeat (2) @(posedge Clock_50);
    #1;
    Reset = 1'b0;
    prev_wr = 0;
    repeat (2) @(posedge Clock_50);
    #1;
    check("after_rst_needs_start", pix_ready, 0);

    // Frame 3: full frame from the base address again.
    begin_frame();
    for (int i = 0; i < NPix; i++) send_pixel(gen_pix(200 + i), 1);
    wait_done(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rgb_sram_writer.md
# rgb_sram_writer

Final write-back stage of the colourspace-conversion milestone. Accepts a row-major stream of 8-bit RGB pixels, packs each pixel pair into three 16-bit SRAM words and writes them sequentially into the RGB region of external SRAM. The checking bench watches exactly these writes. Shares the SRAM port with the YUV fetch logic through a one-bit write grant.

## Interface
- RGB_BASE_ADDR, 18'd146944: first SRAM word of the RGB region.
- NUM_PIXELS, 76800: pixels per frame (320x240). Must be even; total words = 3*NUM_PIXELS/2 = 115200, last address 262143.
- FIFO_DEPTH, 4: pixel buffer entries (power of two, ≥2).

Ports:
- Clock_50  in  1: system clock.
- Reset  in  1: asynchronous, active-high reset.
- start  in  1: one-cycle pulse that begins a frame. Ignored unless in S_IDLE.
- pix_valid  in  1: upstream pixel present.
- pix_ready  out  1: pixel accepted when pix_valid & pix_ready at a rising edge.
- pix_R, pix_G, pix_B  in  8 each: pixel components, already clipped to 0..255.
- write_grant  in  1: SRAM port available this cycle.
- SRAM_address  out  18: registered write address.
- SRAM_write_data  out  16: registered write data.
- SRAM_we_n  out  1: registered, active-low write enable.
- done  out  1: one-cycle pulse after the final word is written.

## Operation
- States: S_IDLE, S_RUN, S_DONE.
- S_IDLE -> S_RUN on start. This transition clears the pixel counter, the word counter and phase, and loads the address register's next value to RGB_BASE_ADDR.
- S_RUN -> S_DONE in the cycle the word counter reaches 3*NUM_PIXELS/2.
- S_DONE -> S_IDLE after one cycle. done=1 during S_DONE.
- pix_ready = (state==S_RUN) & (fifo_count<FIFO_DEPTH) & (pixels_accepted<NUM_PIXELS). Pixels beyond NUM_PIXELS are never accepted.
- Packing phases 0/1/2 for head pixel pair P0, P1:
  - phase 0: word = {R0,G0}; needs count≥1.
  - phase 1: word = {B0,R1}; needs count≥2.
  - phase 2: word = {G1,B1}; needs count≥2. Pops 2 pixels at the end of phase 2.
- Issue condition: S_RUN & write_grant & phase requirement met. When it holds, the next edge:
  - registers the address and data,
  - drives SRAM_we_n=0,
  - increments the address and word counter,
  - advances phase modulo 3.
- Any other cycle: SRAM_we_n=1; address and data hold their last values.
- A push and a pop of 2 in the same cycle are legal. The count updates by +1-2.
- Addresses are strictly increasing with no gaps or repeats. Each location in [RGB_BASE_ADDR, RGB_BASE_ADDR+115199] is written exactly once per frame. No write ever goes below RGB_BASE_ADDR.

## Timing
- Reset values:
  - state S_IDLE; SRAM_we_n=1; SRAM_address=0; SRAM_write_data=0; done=0; pix_ready=0.
  - FIFO empty; counters and phase 0.
- Latency: a pixel accepted at edge t can produce its phase-0 write with SRAM_we_n=0 during cycle t+1→t+2, assuming grant.
- Sustained throughput: 1 word/cycle while grant is high and the FIFO keeps pace. That is 3 cycles per 2 pixels.
- Grant deasserted mid-pair: the phase is held and no data is lost. Resumption continues at the same phase and address.
- done asserts one cycle after the edge that registers the final write (address 262143).
- Reset mid-frame: all state is cleared asynchronously and FIFO contents are discarded. A new start is required.
- start during S_RUN or S_DONE has no effect.

## Structure
- Package rgb_writer_pkg holds:
  - the state enum (S_IDLE, S_RUN, S_DONE),
  - RGB_BASE_ADDR, NUM_PIXELS, RGB_WORDS localparams,
  - a packed 24-bit rgb_pixel_t typedef.
- Sub-module rgb_pixel_fifo: FIFO_DEPTH×24-bit, single push, pop of 0 or 2, exposes count, head and head+1. Reset is asynchronous, active-high.

## Test plan
- Reset, start, 2 pixels (0x11,0x22,0x33) and (0x44,0x55,0x66), grant high -> writes 0x1122@146944, 0x3344@146945, 0x5566@146946, then done. we_n=0 on three consecutive cycles.
- Full frame of 76800 pixels, valid and grant always high -> 115200 writes, addresses 146944..262143 each written once, no address <146944, done one cycle after the last write.
- Grant low for 5 cycles after phase 1 -> no writes during the gap. Phase 2 word {G1,B1} goes to the next address with no duplicate.
- pix_valid held high with grant low -> pix_ready drops after exactly 4 accepts. Raising grant drains in order.
- Reset asserted after 1000 words -> outputs return to reset values immediately. A new start rewrites from 146944.
- start pulsed during S_RUN -> no address reset and no extra writes.
